stack_engine: RTL and testbench

- Responder side of the control unit's stack protocol.
- Services push/pop requests issued by the CALL/RET/INT/RTI sequencers and by PUSH/POP instructions.
- Owns the stack pointer, drives data-memory address and strobes for stack accesses, and reassembles popped PC halves and CCR.
- Sits in the memory stage, between the control unit's strobes and the data memory.

---
 rtl/stack_pkg.sv | 27 ++
 rtl/stack_engine_pc_assembler.sv | 59 +++++
 rtl/stack_engine.sv | 129 ++++++++++++
 tb/tb_stack_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the stack engine: push-source select, read tags, assembler states.
package stack_pkg;

  localparam int CCR_W = 3;
  localparam int PC_W  = 32;

  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_PC_LO = 2'b01,
    SEL_PC_HI = 2'b10,
    SEL_CCR   = 2'b11
  } data_sel_e;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_REG,
    TAG_CCR,
    TAG_PC_HI,
    TAG_PC_LO
  } rd_tag_e;

  typedef enum logic {
    ASM_EMPTY,
    ASM_HAVE_HI
  } asm_state_e;

endpackage

// File: rtl/stack_engine_pc_assembler.sv
// Rebuilds a full PC from the high half followed by the low half popped off the stack.
// A low half arriving with no high half pending is reported as an orphan and dropped.
module pc_assembler
  import stack_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hi_valid_i,
  input  logic                lo_valid_i,
  input  logic [HALF_W-1:0]   half_i,
  output logic [2*HALF_W-1:0] pc_o,
  output logic                pc_valid_o,
  output logic                orphan_o
);

  asm_state_e state_q, state_d;
  logic [HALF_W-1:0]   hi_q;
  logic [2*HALF_W-1:0] pc_q;
  logic                valid_q;
  logic                load_hi, emit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ASM_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ASM_EMPTY:   if (hi_valid_i) state_d = ASM_HAVE_HI;
      ASM_HAVE_HI: if (lo_valid_i) state_d = ASM_EMPTY;
      default:     state_d = ASM_EMPTY;
    endcase
  end

  always_comb begin
    load_hi  = hi_valid_i;
    emit     = (state_q == ASM_HAVE_HI) && lo_valid_i;
    orphan_o = (state_q == ASM_EMPTY) && lo_valid_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_hi) hi_q <= half_i;
      if (emit)    pc_q <= {hi_q, half_i};
      valid_q <= emit;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;

endmodule

// File: rtl/stack_engine.sv
// Stack responder: owns SP, drives stack memory accesses, routes popped words by read tag.
// Build option STACK_BOUNDS_CHECK_EN suppresses push at SP==0 and pop at SP==SP_INIT.
module stack_engine
  import stack_pkg::*;
#(
  parameter int                ADDR_W  = 11,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack,
  input  logic              mem_wr,
  input  logic              mem_rd,
  input  logic [1:0]        mem_data_sel,
  input  logic              pop_pc1,
  input  logic              pop_pc2,
  input  logic              pop_ccr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [CCR_W-1:0]  ccr_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] sp,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_data_valid,
  output logic [PC_W-1:0]   pc_restored,
  output logic              pc_restore_valid,
  output logic [CCR_W-1:0]  ccr_restored,
  output logic              ccr_restore_valid,
  output logic              stack_err
);

  logic [ADDR_W-1:0] sp_q, sp_d, sp_inc;
  rd_tag_e           tag_q, tag_d;
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_v_q;
  logic [CCR_W-1:0]  ccr_q;
  logic              ccr_v_q;
  logic              err_q;
  logic              push_req, pop_req, conflict;
  logic              push_ok, pop_ok, bound_err, orphan;

  assign push_req = stack && mem_wr && !mem_rd;
  assign pop_req  = stack && mem_rd && !mem_wr;
  assign conflict = stack && mem_wr && mem_rd;
  assign sp_inc   = sp_q + ADDR_W'(1);

`ifdef STACK_BOUNDS_CHECK_EN
  assign push_ok   = push_req && (sp_q != '0);
  assign pop_ok    = pop_req && (sp_q != SP_INIT);
  assign bound_err = (push_req && !push_ok) || (pop_req && !pop_ok);
`else
  assign push_ok   = push_req;
  assign pop_ok    = pop_req;
  assign bound_err = 1'b0;
`endif

  assign mem_we   = push_ok;
  assign mem_re   = pop_ok;
  assign mem_addr = pop_ok ? sp_inc : sp_q;

  always_comb begin
    mem_wdata = '0;
    case (data_sel_e'(mem_data_sel))
      SEL_REG:   mem_wdata = reg_data;
      SEL_PC_LO: mem_wdata = DATA_W'(pc_in[PC_W/2-1:0]);
      SEL_PC_HI: mem_wdata = DATA_W'(pc_in[PC_W-1:PC_W/2]);
      SEL_CCR:   mem_wdata = DATA_W'(ccr_in);
      default:   mem_wdata = '0;
    endcase
  end

  always_comb begin
    sp_d  = sp_q;
    tag_d = TAG_NONE;
    if (push_ok) begin
      sp_d = sp_q - ADDR_W'(1);
    end else if (pop_ok) begin
      sp_d = sp_inc;
      if (pop_ccr)      tag_d = TAG_CCR;
      else if (pop_pc2) tag_d = TAG_PC_HI;
      else if (pop_pc1) tag_d = TAG_PC_LO;
      else              tag_d = TAG_REG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q       <= SP_INIT;
      tag_q      <= TAG_NONE;
      pop_data_q <= '0;
      pop_v_q    <= 1'b0;
      ccr_q      <= '0;
      ccr_v_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      tag_q   <= tag_d;
      pop_v_q <= (tag_q == TAG_REG);
      ccr_v_q <= (tag_q == TAG_CCR);
      if (tag_q == TAG_REG) pop_data_q <= mem_rdata;
      if (tag_q == TAG_CCR) ccr_q <= mem_rdata[CCR_W-1:0];
      err_q <= err_q || conflict || bound_err || orphan;
    end
  end

  pc_assembler #(.HALF_W(PC_W/2)) u_pc_assembler (
    .clk        (clk),
    .rst        (rst),
    .hi_valid_i (tag_q == TAG_PC_HI),
    .lo_valid_i (tag_q == TAG_PC_LO),
    .half_i     (mem_rdata[PC_W/2-1:0]),
    .pc_o       (pc_restored),
    .pc_valid_o (pc_restore_valid),
    .orphan_o   (orphan)
  );

  assign sp                = sp_q;
  assign pop_data          = pop_data_q;
  assign pop_data_valid    = pop_v_q;
  assign ccr_restored      = ccr_q;
  assign ccr_restore_valid = ccr_v_q;
  assign stack_err         = err_q;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine: vector table for strobes/SP plus CALL/RET, INT/RTI,
// PUSH/POP, bounds and mid-sequence reset sequences against a synchronous memory model.
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stack = 1'b0, mem_wr = 1'b0, mem_rd = 1'b0;
  logic [1:0]  mem_data_sel = 2'b00;
  logic        pop_pc1 = 1'b0, pop_pc2 = 1'b0, pop_ccr = 1'b0;
  logic [15:0] reg_data = '0;
  logic [31:0] pc_in = '0;
  logic [2:0]  ccr_in = '0;
  logic [15:0] mem_rdata = '0;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [10:0] sp;
  logic [15:0] pop_data;
  logic        pop_data_valid;
  logic [31:0] pc_restored;
  logic        pc_restore_valid;
  logic [2:0]  ccr_restored;
  logic        ccr_restore_valid;
  logic        stack_err;

  stack_engine dut (
    .clk(clk), .rst(rst), .stack(stack), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_data_sel(mem_data_sel), .pop_pc1(pop_pc1), .pop_pc2(pop_pc2), .pop_ccr(pop_ccr),
    .reg_data(reg_data), .pc_in(pc_in), .ccr_in(ccr_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .sp(sp), .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .pc_restored(pc_restored), .pc_restore_valid(pc_restore_valid),
    .ccr_restored(ccr_restored), .ccr_restore_valid(ccr_restore_valid),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Synchronous data memory: read data appears the cycle after mem_re.
  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pc_cnt = 0, pc_cyc = 0, ccr_cnt = 0, ccr_cyc = 0, pop_cnt = 0, pop_cyc = 0;
  logic [31:0] pc_val = '0;
  logic [2:0]  ccr_val = '0;
  logic [15:0] pop_val = '0;
  always @(negedge clk) begin
    if (pc_restore_valid)  begin pc_cnt  <= pc_cnt + 1;  pc_cyc  <= cyc; pc_val  <= pc_restored;  end
    if (ccr_restore_valid) begin ccr_cnt <= ccr_cnt + 1; ccr_cyc <= cyc; ccr_val <= ccr_restored; end
    if (pop_data_valid)    begin pop_cnt <= pop_cnt + 1; pop_cyc <= cyc; pop_val <= pop_data;     end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    stack = 1'b0; mem_wr = 1'b0; mem_rd = 1'b0;
    pop_pc1 = 1'b0; pop_pc2 = 1'b0; pop_ccr = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1; #7; rst = 1'b0;
    tick(1);
  endtask

  task automatic push(input logic [1:0] sel);
    stack = 1'b1; mem_wr = 1'b1; mem_data_sel = sel;
    tick(1);
    idle();
  endtask

  task automatic pop(input logic p1, input logic p2, input logic pc, output int c);
    stack = 1'b1; mem_rd = 1'b1; pop_pc1 = p1; pop_pc2 = p2; pop_ccr = pc;
    c = cyc;
    tick(1);
    idle();
  endtask

  typedef struct packed {
    logic        stk, wr, rd;
    logic [1:0]  sel;
    logic [15:0] rdat;
    logic [31:0] pc;
    logic [2:0]  ccr;
    logic        e_we, e_re;
    logic [10:0] e_addr;
    logic [15:0] e_wd;
    logic [10:0] e_sp;
    logic        e_err;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  localparam logic [10:0] SP_TOP = 11'h7FF;
`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic        BC = 1'b1;
`else
  localparam logic        BC = 1'b0;
`endif

  initial begin
    int c0, c1, c2, c3, bp, bc, bd;
    vec[0] = '{1'b1,1'b1,1'b0,2'b01,16'h0000,32'h1234ABCD,3'b000,1'b1,1'b0,11'h7FF,16'hABCD,11'h7FE,1'b0};
    vec[1] = '{1'b1,1'b1,1'b0,2'b10,16'h0000,32'h1234ABCD,3'b000,1'b1,1'b0,11'h7FE,16'h1234,11'h7FD,1'b0};
    vec[2] = '{1'b1,1'b1,1'b0,2'b11,16'h0000,32'h00000000,3'b101,1'b1,1'b0,11'h7FD,16'h0005,11'h7FC,1'b0};
    vec[3] = '{1'b1,1'b1,1'b0,2'b00,16'h00FF,32'h00000000,3'b000,1'b1,1'b0,11'h7FC,16'h00FF,11'h7FB,1'b0};
    vec[4] = '{1'b0,1'b1,1'b0,2'b00,16'h0000,32'h00000000,3'b000,1'b0,1'b0,11'h000,16'h0000,11'h7FB,1'b0};
    vec[5] = '{1'b0,1'b0,1'b1,2'b00,16'h0000,32'h00000000,3'b000,1'b0,1'b0,11'h000,16'h0000,11'h7FB,1'b0};
    vec[6] = '{1'b1,1'b0,1'b1,2'b00,16'h0000,32'h00000000,3'b000,1'b0,1'b1,11'h7FC,16'h0000,11'h7FC,1'b0};
    vec[7] = '{1'b1,1'b0,1'b1,2'b00,16'h0000,32'h00000000,3'b000,1'b0,1'b1,11'h7FD,16'h0000,11'h7FD,1'b0};
    vec[8] = '{1'b1,1'b1,1'b1,2'b00,16'h0000,32'h00000000,3'b000,1'b0,1'b0,11'h000,16'h0000,11'h7FD,1'b1};
    vec[9] = '{1'b0,1'b1,1'b1,2'b00,16'h0000,32'h00000000,3'b000,1'b0,1'b0,11'h000,16'h0000,11'h7FD,1'b1};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_sp", sp, SP_TOP);
    check("rst_err", stack_err, 0);
    check("rst_pc_valid", pc_restore_valid, 0);
    check("rst_pc", pc_restored, 0);
    check("rst_ccr", ccr_restored, 0);
    check("rst_pop_data", pop_data, 0);
    check("rst_pop_valid", pop_data_valid, 0);
    check("rst_ccr_valid", ccr_restore_valid, 0);
    #5 rst = 1'b0;
    tick(1);

    // Vector table: strobes, address and write data in-cycle; SP and error after the edge
    for (int i = 0; i < NV; i++) begin
      vec_t v;
      v = vec[i];
      stack = v.stk; mem_wr = v.wr; mem_rd = v.rd; mem_data_sel = v.sel;
      reg_data = v.rdat; pc_in = v.pc; ccr_in = v.ccr;
      #1;
      check($sformatf("v%0d_we", i), mem_we, v.e_we);
      check($sformatf("v%0d_re", i), mem_re, v.e_re);
      if (v.e_we || v.e_re) check($sformatf("v%0d_addr", i), mem_addr, v.e_addr);
      if (v.e_we) check($sformatf("v%0d_wdata", i), mem_wdata, v.e_wd);
      @(posedge clk); #1;
      idle();
      check($sformatf("v%0d_sp", i), sp, v.e_sp);
      check($sformatf("v%0d_err", i), stack_err, v.e_err);
    end

    // CALL then RET
    do_reset();
    pc_in = 32'h1234_ABCD;
    push(2'b01); push(2'b10);
    pc_in = '0;
    check("call_sp", sp, 11'h7FD);
    bp = pc_cnt;
    pop(1'b0, 1'b1, 1'b0, c2);
    pop(1'b1, 1'b0, 1'b0, c1);
    tick(4);
    check("ret_pc_pulses", pc_cnt - bp, 1);
    check("ret_pc", pc_val, 32'h1234_ABCD);
    check("ret_latency", pc_cyc - c1, 2);
    check("ret_sp", sp, SP_TOP);
    check("ret_err", stack_err, 0);

    // INT then RTI, back-to-back pops
    do_reset();
    pc_in = 32'hCAFE_0042; ccr_in = 3'b101;
    push(2'b01); push(2'b10); push(2'b11);
    pc_in = '0; ccr_in = '0;
    bp = pc_cnt; bc = ccr_cnt;
    pop(1'b0, 1'b0, 1'b1, c0);
    pop(1'b0, 1'b1, 1'b0, c2);
    pop(1'b1, 1'b0, 1'b0, c3);
    tick(5);
    check("rti_ccr_pulses", ccr_cnt - bc, 1);
    check("rti_ccr", ccr_val, 3'b101);
    check("rti_ccr_latency", ccr_cyc - c0, 2);
    check("rti_pc_pulses", pc_cnt - bp, 1);
    check("rti_pc", pc_val, 32'hCAFE_0042);
    check("rti_pc_latency", pc_cyc - c3, 2);
    check("rti_sp", sp, SP_TOP);
    check("rti_err", stack_err, 0);

    // PUSH Rs / POP Rd
    do_reset();
    reg_data = 16'h00FF;
    push(2'b00);
    reg_data = '0;
    bd = pop_cnt;
    pop(1'b0, 1'b0, 1'b0, c0);
    tick(3);
    check("pop_pulses", pop_cnt - bd, 1);
    check("pop_data", pop_val, 16'h00FF);
    check("pop_latency", pop_cyc - c0, 2);
    check("pop_sp", sp, SP_TOP);

    // Pop from an empty stack
    do_reset();
    stack = 1'b1; mem_rd = 1'b1;
    #1;
    check("empty_pop_re", mem_re, !BC);
    tick(1);
    idle();
    check("empty_pop_sp", sp, BC ? SP_TOP : 11'h000);
    check("empty_pop_err", stack_err, BC);

    // Reset between the pc2 and pc1 pops
    do_reset();
    pc_in = 32'h5555_AAAA;
    push(2'b01); push(2'b10);
    pc_in = '0;
    bp = pc_cnt;
    pop(1'b0, 1'b1, 1'b0, c2);
    rst = 1'b1;
    #2;
    check("midrst_sp", sp, SP_TOP);
    check("midrst_pc_valid", pc_restore_valid, 0);
    #6 rst = 1'b0;
    tick(2);
    check("midrst_err_clear", stack_err, 0);
    pop(1'b1, 1'b0, 1'b0, c1);
    tick(4);
    check("midrst_no_pc", pc_cnt - bp, 0);
    check("midrst_orphan_err", stack_err, 1);
    check("midrst_sp_after", sp, BC ? SP_TOP : 11'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
